// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline package for the ID/EX stage.
// Holds the control-field widths, the bit positions of RegWrite and
// MemRead inside their control groups, the ID/EX FSM state encoding and
// a small helper used by the hazard comparator.
package id_ex_stage_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam int WB_W = 2;   // [1] RegWrite, [0] MemtoReg
    localparam int M_W  = 2;   // [1] MemRead,  [0] MemWrite
    localparam int EX_W = 4;   // RegDst, ALUSrc, ALUOp[1:0]

    localparam int WB_REG_WRITE_BIT = 1;
    localparam int M_MEM_READ_BIT   = 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_ex_state_e;

    // Register 0 is hard-wired to zero, so it can never carry a real dependency.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use hazard comparator.
// Ports:
//   mem_read    - MemRead of the instruction currently held in ID/EX
//   ex_rt_addr  - destination (rt) of that load
//   id_rs_addr  - rs of the instruction sitting in IF/ID
//   id_rt_addr  - rt of the instruction sitting in IF/ID
//   hazard      - high when the IF/ID instruction needs the load result
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    output logic                  hazard
);

    always_comb begin
        hazard = mem_read
              && !is_zero_reg(ex_rt_addr)
              && ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall control.
// Optional feature: define STALL_COUNT_EN to add stall_cnt_o, a wrapping
// 32-bit count of load-use bubbles inserted.
// Ports:
//   clk_i, rst_n_i                    - clock, async active-low reset
//   ifid_rs_i/rt_i/rd_i               - IF/ID register addresses
//   rsdata_i, rtdata_i, imm_i         - register file data, sign-extended imm
//   ctrl_wb_i, ctrl_m_i, ctrl_ex_i    - decoded control groups
//   flush_i                           - branch taken, squash ID
//   hold_i                            - downstream freeze (no register moves)
//   rsaddr_o..ex_o                    - registered ID/EX contents
//   pc_write_o, ifid_write_o          - 1 = upstream may advance
//   bubble_o                          - ID/EX holds an inserted bubble
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_RUN    | normal flow; ID/EX follows ID (or takes a flush bubble)
// ST_BUBBLE | ID/EX holds a load-use bubble; next enabled edge resumes
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic [REG_ADDR_W-1:0] ifid_rd_i,
    input  logic [DATA_W-1:0]     rsdata_i,
    input  logic [DATA_W-1:0]     rtdata_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [WB_W-1:0]       ctrl_wb_i,
    input  logic [M_W-1:0]        ctrl_m_i,
    input  logic [EX_W-1:0]       ctrl_ex_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic [REG_ADDR_W-1:0] rsaddr_o,
    output logic [REG_ADDR_W-1:0] rtaddr_o,
    output logic [REG_ADDR_W-1:0] rdaddr_o,
    output logic [DATA_W-1:0]     rsdata_o,
    output logic [DATA_W-1:0]     rtdata_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [WB_W-1:0]       wb_o,
    output logic [M_W-1:0]        m_o,
    output logic [EX_W-1:0]       ex_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  bubble_o
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    id_ex_state_e state_q, state_d;
    logic         hazard;
    logic         load_en;
    logic         insert_bubble;
    logic         last_flush_q;

    hazard_detect u_hazard_detect (
        .mem_read   (m_o[M_MEM_READ_BIT]),
        .ex_rt_addr (rtaddr_o),
        .id_rs_addr (ifid_rs_i),
        .id_rt_addr (ifid_rt_i),
        .hazard     (hazard)
    );

    always_comb begin
        load_en       = !hold_i;
        insert_bubble = hazard || flush_i;
        state_d       = state_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        if (load_en) begin
            // A taken branch overrides the stall: the redirect must proceed.
            pc_write_o   = !hazard || flush_i;
            ifid_write_o = !hazard || flush_i;
            case (state_q)
                ST_RUN:    if (hazard && !flush_i) state_d = ST_BUBBLE;
                ST_BUBBLE: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
        bubble_o = (state_q == ST_BUBBLE) || last_flush_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsaddr_o     <= '0;
            rtaddr_o     <= '0;
            rdaddr_o     <= '0;
            rsdata_o     <= '0;
            rtdata_o     <= '0;
            imm_o        <= '0;
            wb_o         <= '0;
            m_o          <= '0;
            ex_o         <= '0;
            last_flush_q <= 1'b0;
        end else if (load_en) begin
            last_flush_q <= flush_i;
            if (insert_bubble) begin
                // Only the control groups are zeroed; operand fields keep
                // their old values so forwarding compares stay quiet.
                wb_o <= '0;
                m_o  <= '0;
                ex_o <= '0;
            end else begin
                rsaddr_o <= ifid_rs_i;
                rtaddr_o <= ifid_rt_i;
                rdaddr_o <= ifid_rd_i;
                rsdata_o <= rsdata_i;
                rtdata_o <= rtdata_i;
                imm_o    <= imm_i;
                wb_o     <= ctrl_wb_i;
                m_o      <= ctrl_m_i;
                ex_o     <= ctrl_ex_i;
            end
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_BUBBLE)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the expected
// outputs for each cycle, a monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [4:0]  ifid_rs_i = '0, ifid_rt_i = '0, ifid_rd_i = '0;
    logic [31:0] rsdata_i = '0, rtdata_i = '0, imm_i = '0;
    logic [1:0]  ctrl_wb_i = '0, ctrl_m_i = '0;
    logic [3:0]  ctrl_ex_i = '0;
    logic        flush_i = 1'b0, hold_i = 1'b0;
    logic [4:0]  rsaddr_o, rtaddr_o, rdaddr_o;
    logic [31:0] rsdata_o, rtdata_o, imm_o;
    logic [1:0]  wb_o, m_o;
    logic [3:0]  ex_o;
    logic        pc_write_o, ifid_write_o, bubble_o;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_o;
`endif

    id_ex_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_rd_i(ifid_rd_i),
        .rsdata_i(rsdata_i), .rtdata_i(rtdata_i), .imm_i(imm_i),
        .ctrl_wb_i(ctrl_wb_i), .ctrl_m_i(ctrl_m_i), .ctrl_ex_i(ctrl_ex_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .rsaddr_o(rsaddr_o), .rtaddr_o(rtaddr_o), .rdaddr_o(rdaddr_o),
        .rsdata_o(rsdata_o), .rtdata_o(rtdata_o), .imm_o(imm_o),
        .wb_o(wb_o), .m_o(m_o), .ex_o(ex_o),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .bubble_o(bubble_o)
`ifdef STALL_COUNT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst_n, hold, flush;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
    } stim_t;

    // Contents of the ID/EX register as the pipeline sees it.
    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
        logic        stalled;     // load-use bubble currently in ID/EX
        logic        flushed;     // last accepted load was a flush
        logic [31:0] stalls;
    } model_t;

    typedef struct {
        model_t md;
        logic   pc_write;
        logic   bubble;
    } exp_t;

    model_t md;
    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic   prev_hold = 1'b0, prev_flush = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.hold = 1'b0; s.flush = 1'b0;
        s.rs = '0; s.rt = '0; s.rd = '0;
        s.rsd = '0; s.rtd = '0; s.imm = '0;
        s.wb = '0; s.m = '0; s.ex = '0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic uses_load;
        @(negedge clk_i);
        rst_n_i = s.rst_n; hold_i = s.hold; flush_i = s.flush;
        ifid_rs_i = s.rs; ifid_rt_i = s.rt; ifid_rd_i = s.rd;
        rsdata_i = s.rsd; rtdata_i = s.rtd; imm_i = s.imm;
        ctrl_wb_i = s.wb; ctrl_m_i = s.m; ctrl_ex_i = s.ex;
        if (!s.rst_n) md = '0;
        // The instruction in ID reads the register a pending load writes.
        uses_load = md.m[1] && (md.rt != 5'd0) && (md.rt == s.rs || md.rt == s.rt);
        e.md       = md;
        e.pc_write = !s.hold && (!uses_load || s.flush);
        e.bubble   = md.stalled || md.flushed;
        exp_q.push_back(e);
        @(posedge clk_i);
        if (s.rst_n && !s.hold) begin
            if (uses_load || s.flush) begin
                md.wb = '0; md.m = '0; md.ex = '0;
                md.stalled = !md.stalled && uses_load && !s.flush;
                if (md.stalled) md.stalls = md.stalls + 32'd1;
            end else begin
                md.rs = s.rs; md.rt = s.rt; md.rd = s.rd;
                md.rsd = s.rsd; md.rtd = s.rtd; md.imm = s.imm;
                md.wb = s.wb; md.m = s.m; md.ex = s.ex;
                md.stalled = 1'b0;
            end
            md.flushed = s.flush;
        end
        prev_hold = s.hold;
        prev_flush = s.flush;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_write",   32'(pc_write_o),   32'(e.pc_write));
                chk("ifid_write", 32'(ifid_write_o), 32'(e.pc_write));
                chk("bubble",     32'(bubble_o),     32'(e.bubble));
                chk("rsaddr",     32'(rsaddr_o),     32'(e.md.rs));
                chk("rtaddr",     32'(rtaddr_o),     32'(e.md.rt));
                chk("rdaddr",     32'(rdaddr_o),     32'(e.md.rd));
                chk("rsdata",     rsdata_o,          e.md.rsd);
                chk("rtdata",     rtdata_o,          e.md.rtd);
                chk("imm",        imm_o,             e.md.imm);
                chk("wb",         32'(wb_o),         32'(e.md.wb));
                chk("m",          32'(m_o),          32'(e.md.m));
                chk("ex",         32'(ex_o),         32'(e.md.ex));
`ifdef STALL_COUNT_EN
                chk("stall_cnt",  stall_cnt_o,       e.md.stalls);
`endif
            end
        end
    end

    task automatic load_then_use(input logic [4:0] r, input logic flush_on_use);
        stim_t s;
        s = idle(); s.m = 2'b10; s.wb = 2'b11; s.rt = r; s.rs = 5'd1; s.rd = 5'd3;
        s.rsd = 32'h1111_0000; s.rtd = 32'h2222_0000; s.imm = 32'h0000_0044; s.ex = 4'b0100;
        step(s);
        s = idle(); s.rs = r; s.rt = 5'd30; s.m = 2'b01; s.wb = 2'b10; s.ex = 4'b1010;
        s.rsd = 32'hDEAD_BEEF; s.flush = flush_on_use;
        step(s);
    endtask

    initial begin : driver
        stim_t s;
        md = '0;
        // Reset with hold low: everything zero, upstream allowed to advance.
        s = idle(); s.rst_n = 1'b0;
        step(s);
        step(s);
        // Classic load-use stall, then the bubble, then back to RUN.
        load_then_use(5'd5, 1'b0);
        s = idle(); s.rs = 5'd5; s.rd = 5'd8; s.rsd = 32'hCAFE_0001; s.wb = 2'b10;
        step(s);
        step(idle());
        // A load to r0 never stalls.
        s = idle(); s.m = 2'b10; s.rt = 5'd0;
        step(s);
        s = idle(); s.rs = 5'd0; s.rt = 5'd0;
        step(s);
        // Flush coinciding with a hazard: bubble inserted, PC still advances.
        load_then_use(5'd7, 1'b1);
        s = idle(); s.rs = 5'd7; s.rt = 5'd7; s.m = 2'b01;
        step(s);
        step(idle());
        // Hold freezes everything for three cycles while data changes.
        s = idle(); s.rsd = 32'h0BAD_F00D; s.rs = 5'd12; s.wb = 2'b01;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.hold = 1'b1; s.rsd = 32'h5000_0000 + 32'(i); s.rs = 5'd20;
            step(s);
        end
        s = idle(); s.rsd = 32'h6000_0006; s.rs = 5'd21;
        step(s);
        step(idle());
        // Reset asserted while the bubble sits in ID/EX.
        load_then_use(5'd9, 1'b0);
        s = idle(); s.rst_n = 1'b0; s.rs = 5'd9;
        step(s);
        s = idle(); s.rs = 5'd9;
        step(s);
        step(idle());
`ifdef STALL_COUNT_EN
        load_then_use(5'd4, 1'b0);
        step(idle());
        load_then_use(5'd6, 1'b0);
        step(idle());
        #1;
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        md.stalls = 32'hFFFF_FFFF;
        load_then_use(5'd11, 1'b0);
        step(idle());
`endif
        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.hold  = ($urandom_range(0, 6) == 0);
            s.flush = (prev_flush && prev_hold) ? 1'b1 : ($urandom_range(0, 9) == 0);
            s.rs  = 5'($urandom_range(0, 7));
            s.rt  = 5'($urandom_range(0, 7));
            s.rd  = 5'($urandom);
            s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
            s.wb  = 2'($urandom);
            s.m   = 2'($urandom_range(0, 3));
            s.ex  = 4'($urandom);
            if ($urandom_range(0, 99) == 0 && !s.hold) s.rst_n = 1'b0;
            step(s);
        end
        @(negedge clk_i);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs ifid_rs_i, ifid_rt_i, ifid_rd_i, each 5 bits: IF/ID register addresses.
REQ-004 SHALL have inputs rsdata_i, rtdata_i, imm_i, each 32 bits: register file read data and sign-extended immediate.
REQ-005 SHALL have inputs ctrl_wb_i (2 bits: [1] RegWrite, [0] MemtoReg), ctrl_m_i (2 bits: [1] MemRead, [0] MemWrite) and ctrl_ex_i (4 bits: RegDst, ALUSrc, ALUOp[1:0]).
REQ-006 SHALL have inputs flush_i (1, branch taken, squash ID) and hold_i (1, downstream freeze).
REQ-007 SHALL have outputs rsaddr_o, rtaddr_o, rdaddr_o (5 each), rsdata_o, rtdata_o, imm_o (32 each), wb_o (2), m_o (2), ex_o (4): registered ID/EX contents feeding the EX stage and the forwarding unit.
REQ-008 SHALL have outputs pc_write_o, ifid_write_o (1 each, 1 = advance) and bubble_o (1, high while ID/EX holds an inserted bubble).

Function
REQ-009 SHALL detect load-use hazard combinationally: m_o[1]==1, rtaddr_o!=0, and rtaddr_o equals ifid_rs_i or ifid_rt_i.
REQ-010 SHALL implement FSM states RUN and BUBBLE; RUN->BUBBLE on an enabled edge with hazard and no flush_i; BUBBLE->RUN on the next enabled edge; otherwise stay RUN.
REQ-011 SHALL drive pc_write_o=ifid_write_o=0 while a hazard is detected or hold_i=1; otherwise 1.
REQ-012 SHALL, on an enabled edge with hazard or flush_i, load wb_o, m_o, ex_o with zero and hold address/data fields at their previous values.
REQ-013 SHALL, on an enabled edge with neither hazard nor flush_i, capture all inputs with one-cycle latency.
REQ-014 SHALL treat a clock edge as enabled only when hold_i=0; with hold_i=1 all registers and FSM state SHALL be unchanged.
REQ-015 SHALL give hold_i priority over flush_i over hazard; the upstream source SHALL keep flush_i high until hold_i drops.
REQ-016 SHALL, when flush_i and hazard coincide, insert the bubble, stay in RUN, and drive pc_write_o=1 so the branch redirect proceeds.
REQ-017 SHALL assert bubble_o exactly when the FSM is in BUBBLE or the last enabled load was a flush.
REQ-018 SHALL never detect a hazard against register 0.

Reset
REQ-019 SHALL, while rst_n_i=0, asynchronously clear every registered output to 0, set FSM to RUN and clear bubble_o.
REQ-020 SHALL drive pc_write_o=ifid_write_o=1 during reset when hold_i=0 (no hazard is possible).
REQ-021 SHALL, on reset assertion mid-stall, abandon the stall; first cycle after release is RUN.

Configuration
REQ-022 SHALL, with STALL_COUNT_EN defined, add output stall_cnt_o (32 bits) counting enabled edges that insert a load-use bubble, cleared by reset, wrapping 0xFFFFFFFF->0.
REQ-023 SHALL, without STALL_COUNT_EN, omit stall_cnt_o and its counter entirely.

Structure
REQ-024 SHALL take control-field widths, bit positions of RegWrite/MemRead, and FSM state encoding from the shared pipeline package.
REQ-025 SHALL place hazard comparison in one sub-module, hazard_detect; registers and FSM stay in id_ex_stage.

Verification
REQ-026 SHALL check: reset then ctrl_m_i=2'b10, ifid_rt_i=5 loaded; next ifid_rs_i=5 -> pc_write_o=0, ifid_write_o=0, next cycle m_o=0, bubble_o=1, then RUN.
REQ-027 SHALL check: load with rtaddr 0, ifid_rs_i=0 -> no stall, pc_write_o=1.
REQ-028 SHALL check: flush_i=1 with hazard -> control outputs 0, pc_write_o=1, FSM stays RUN.
REQ-029 SHALL check: hold_i=1 for 3 cycles with rsdata_i changing -> rsdata_o unchanged, pc_write_o=0; release -> capture resumes next edge.
REQ-030 SHALL check: rst_n_i low mid-BUBBLE -> all outputs 0 immediately; STALL_COUNT_EN build: two load-use stalls -> stall_cnt_o=2, counter preset near 0xFFFFFFFF wraps to 0.
